// File: rtl/pwm_capture_pkg.sv
// Shared register-map constants and helpers for the pwm_capture block.
// STATUS_MASK depends on PWM_CAPTURE_EDGE_EN (rising-edge status bits present or not).
package pwm_capture_pkg;

  localparam int         NUM_CHAN = 3;
  localparam logic [7:0] DUTY_MAX = 8'hFF;

  typedef enum logic [1:0] {
    DUTY1  = 2'd0,
    DUTY2  = 2'd1,
    DUTY3  = 2'd2,
    STATUS = 2'd3
  } addr_e;

  localparam int STAT_FRAME_DONE = 7;
  localparam int STAT_EDGE_LSB   = 0;

`ifdef PWM_CAPTURE_EDGE_EN
  localparam logic [7:0] STATUS_MASK = 8'h87;
`else
  localparam logic [7:0] STATUS_MASK = 8'h80;
`endif

  // Clamp a high-count frame total into the 8-bit duty register.
  function automatic logic [7:0] sat_duty(input logic [31:0] total);
    return (total > 32'(DUTY_MAX)) ? DUTY_MAX : total[7:0];
  endfunction

endpackage

// File: rtl/pwm_capture_chan.sv
// One PWM channel: two-flop synchronizer, high-cycle accumulator, duty latch,
// and (with PWM_CAPTURE_EDGE_EN) a rising-edge pulse on the synchronized level.
module pwm_capture_chan
  import pwm_capture_pkg::*;
#(
  parameter int FRAME_BITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm,
  input  logic       frame_end,
  output logic [7:0] duty,
  output logic       rise
);

  // One extra bit so a full frame of high cycles still fits before saturation.
  localparam int ACC_W = FRAME_BITS + 1;

  logic [1:0]       sync;
  logic             level;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] total;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], pwm};
  end

  assign level = sync[1];
  assign total = acc + ACC_W'(level);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            acc <= '0;
    else if (frame_end) acc <= '0;
    else if (level)     acc <= acc + ACC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            duty <= '0;
    else if (frame_end) duty <= sat_duty(32'(total));
  end

`ifdef PWM_CAPTURE_EDGE_EN
  logic level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign rise = level & ~level_q;
`else
  assign rise = 1'b0;
`endif

endmodule

// File: rtl/pwm_capture.sv
// Three-channel PWM duty-cycle capture with a small read/write register map.
// Rising-edge status bits exist only when PWM_CAPTURE_EDGE_EN is defined.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int FRAME_BITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_en,
  input  logic [1:0] addr,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       in1,
  input  logic       in2,
  input  logic       in3
);

  logic [FRAME_BITS-1:0] frame_cnt;
  logic                  frame_end;
  logic [NUM_CHAN-1:0]   pwm_in;
  logic [NUM_CHAN-1:0]   rise;
  logic [7:0]            duty [NUM_CHAN];
  logic [7:0]            status;
  logic [7:0]            status_set;
  logic [7:0]            status_clr;
  logic [7:0]            rd_mux;

  assign pwm_in    = {in3, in2, in1};
  assign frame_end = &frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_cnt <= '0;
    else     frame_cnt <= frame_cnt + FRAME_BITS'(1);
  end

  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
    pwm_capture_chan #(.FRAME_BITS(FRAME_BITS)) u_chan (
      .clk       (clk),
      .rst       (rst),
      .pwm       (pwm_in[i]),
      .frame_end (frame_end),
      .duty      (duty[i]),
      .rise      (rise[i])
    );
  end

  // NOTE: default every always_comb output first so no path can infer a latch.
  always_comb begin
    status_set                            = '0;
    status_set[STAT_FRAME_DONE]           = frame_end;
    status_set[STAT_EDGE_LSB +: NUM_CHAN] = rise;
  end

  assign status_clr = (wr_en && addr_e'(addr) == STATUS) ? wr_data : '0;

  // Set is OR-ed in after the clear so a same-cycle set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) status <= '0;
    else     status <= ((status & ~status_clr) | status_set) & STATUS_MASK;
  end

  always_comb begin
    rd_mux = '0;
    unique case (addr_e'(addr))
      DUTY1:  rd_mux = duty[0];
      DUTY2:  rd_mux = duty[1];
      DUTY3:  rd_mux = duty[2];
      STATUS: rd_mux = status;
    endcase
  end

  // Read data is captured from pre-edge state, so a concurrent write or latch is not visible yet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a frame-level model checks every read cycle,
// plus hand-computed literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int FRAME_BITS = 8;
  localparam int FRAME_LEN  = 1 << FRAME_BITS;

`ifdef PWM_CAPTURE_EDGE_EN
  localparam logic [7:0] M_MASK    = 8'h87;
  localparam logic [7:0] EXP_EDGE3 = 8'h04;
`else
  localparam logic [7:0] M_MASK    = 8'h80;
  localparam logic [7:0] EXP_EDGE3 = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rd_en, wr_en;
  logic [1:0] addr;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid;
  logic       in1, in2, in3;

  pwm_capture #(.FRAME_BITS(FRAME_BITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .addr     (addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level model: each frame's duty is the number of high samples the
  // channel saw (inputs become visible two edges after they are sampled).
  int         m_pos;
  int         m_cnt  [3];
  int         m_duty [3];
  logic [2:0] m_pipe [2];
  logic [2:0] m_prev;
  logic [2:0] m_eff;
  logic [7:0] m_status, m_set, m_clr;
  logic [7:0] m_rd_data;
  logic       m_rd_valid;

  function automatic int min255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos = 0;
      for (int c = 0; c < 3; c++) begin
        m_cnt[c]  = 0;
        m_duty[c] = 0;
      end
      m_pipe[0] = '0; m_pipe[1] = '0; m_prev = '0;
      m_status = '0; m_rd_data = '0; m_rd_valid = 1'b0;
    end else begin
      m_rd_valid = rd_en;
      if (rd_en) m_rd_data = (addr == 2'd3) ? m_status : 8'(m_duty[addr]);
      m_eff     = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = {in3, in2, in1};
      m_set = '0;
      for (int c = 0; c < 3; c++) begin
        m_cnt[c] += int'(m_eff[c]);
        if (m_eff[c] && !m_prev[c]) m_set[c] = 1'b1;
      end
      if (m_pos == FRAME_LEN - 1) begin
        m_set[7] = 1'b1;
        for (int c = 0; c < 3; c++) begin
          m_duty[c] = min255(m_cnt[c]);
          m_cnt[c]  = 0;
        end
      end
      m_clr    = (wr_en && addr == 2'd3) ? wr_data : 8'h00;
      m_status = ((m_status & ~m_clr) | m_set) & M_MASK;
      m_prev   = m_eff;
      m_pos    = (m_pos + 1) % FRAME_LEN;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model_rd_valid", rd_valid, m_rd_valid);
      check("model_rd_data", rd_data, m_rd_data);
    end
  end

  // in2: period-256 waveform, 64 cycles high, arbitrary starting phase.
  initial begin
    int ph;
    ph  = 100;
    in2 = 1'b0;
    forever begin
      @(negedge clk);
      in2 = (ph < 64);
      ph  = (ph + 1) % 256;
    end
  end

  int t;

  task automatic step();
    @(negedge clk);
    t++;
  endtask

  task automatic go_to(input int n);
    while (t < n) step();
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] mask, input logic [7:0] exp,
                    input string name);
    addr  = a;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check({name, "_valid"}, rd_valid, 1);
    check(name, rd_data & mask, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    addr    = a;
    wr_data = d;
    wr_en   = 1'b1;
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0;
    in1 = 1'b1; in3 = 1'b0; t = 0;
    repeat (3) @(negedge clk);
    check("reset_rd_data", rd_data, 0);
    check("reset_rd_valid", rd_valid, 0);
    rst = 1'b0;
    t   = 0;

    go_to(20);
    rd(2'd3, 8'h80, 8'h00, "status_before_frame");

    // First frame: in1 high, two samples lost to the synchronizer -> 254.
    go_to(255);
    rd(2'd0, 8'hFF, 8'd0,   "duty1_latch_cycle");
    rd(2'd0, 8'hFF, 8'd254, "duty1_frame1");
    rd(2'd3, 8'h80, 8'h80,  "frame_done_set");

    rd(2'd0, 8'hFF, 8'd254, "duty1_pulse");
    step();
    check("rd_valid_one_cycle", rd_valid, 0);

    addr = 2'd0; wr_data = 8'h55; wr_en = 1'b1; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    check("rd_wr_same_addr", rd_data, 254);
    rd(2'd0, 8'hFF, 8'd254, "duty1_after_write");

    wr(2'd3, 8'h80);
    rd(2'd3, 8'h80, 8'h00, "frame_done_cleared");

    go_to(512);
    rd(2'd0, 8'hFF, 8'd255, "duty1_saturated");
    rd(2'd1, 8'hFF, 8'd64,  "duty2_periodic");
    rd(2'd2, 8'hFF, 8'd0,   "duty3_zero");
    rd(2'd3, 8'h80, 8'h80,  "frame_done_frame2");

    go_to(600);
    wr(2'd3, 8'h80);
    rd(2'd3, 8'h80, 8'h00, "frame_done_clear2");
    go_to(767);
    wr(2'd3, 8'h80);
    rd(2'd3, 8'h80, 8'h80, "set_wins_over_clear");

    go_to(790);
    wr(2'd3, 8'h04);
    rd(2'd3, 8'h04, 8'h00, "edge3_before");
    go_to(800);
    in3 = 1'b1;
    go_to(803);
    rd(2'd3, 8'h04, EXP_EDGE3, "edge3_set");
    wr(2'd3, 8'h04);
    rd(2'd3, 8'h04, 8'h00, "edge3_w1c");

    go_to(900);
    #2 rst = 1'b1;
    step();
    step();
    check("mid_reset_rd_data", rd_data, 0);
    check("mid_reset_rd_valid", rd_valid, 0);
    rst = 1'b0;
    t   = 0;
    rd(2'd0, 8'hFF, 8'd0,  "duty1_after_reset");
    rd(2'd1, 8'hFF, 8'd0,  "duty2_after_reset");
    rd(2'd2, 8'hFF, 8'd0,  "duty3_after_reset");
    rd(2'd3, 8'h80, 8'h00, "status_after_reset");
    go_to(255);
    rd(2'd3, 8'h80, 8'h00, "no_latch_before_256");
    rd(2'd3, 8'h80, 8'h80, "latch_256_after_release");
    rd(2'd0, 8'hFF, 8'd254, "duty1_after_reset_frame");
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
